// File: rtl/ula_acumulador_seq.sv
// -----------------------------------------------------------------------------
// ula_acumulador_seq
//
// Clocked accumulator/controller stage placed around the combinational 4-bit
// ULA (AND, OR, NOT, NAND, ADD, SUB, LSL, LSR). Commands arrive over a
// valid/ready handshake. The stage drives the ULA operand/opcode inputs from
// registered state, captures the ULA result into a 4-bit accumulator, and
// presents the result over a valid/ready response handshake. The stage does
// no arithmetic itself: every operation result comes from the external ULA.
//
// Ports
//   clk               system clock, all state changes on the rising edge
//   rst               synchronous, active-high reset
//   cmd_valid         command present
//   cmd_ready         stage can accept a command (idle and not in reset)
//   cmd_load          1 = load cmd_dado into the accumulator, 0 = run cmd_op
//   cmd_op   [2:0]    ULA opcode
//   cmd_dado [3:0]    operand B, or the load value
//   alu_a_out [3:0]   to ULA a_in (always the accumulator)
//   alu_b_out [3:0]   to ULA b_in (latched operand)
//   alu_op_out [2:0]  to ULA op_sel (latched opcode)
//   alu_resultado_in  from ULA resultado_out
//   acc_out  [3:0]    accumulator
//   zero_flag         registered, 1 when the accumulator is zero
//   resp_valid        result available on acc_out
//   resp_ready        consumer accepts the response
//   op_count_out[7:0] completed-response counter (only with the macro below)
//
// Build option
//   ULA_ACC_CONTADOR_EN : adds op_count_out, an 8-bit wrapping counter of
//                         response handshakes (loads included), cleared by rst.
//
// Timing
//   ULA command accepted at edge N -> result and resp_valid after edge N+1.
//   Load command accepted at edge N -> result and resp_valid after edge N.
//   After the response handshake the stage is idle for the next cycle, so the
//   best case is one ULA command every 3 cycles and one load every 2 cycles.
// -----------------------------------------------------------------------------
module ula_acumulador_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_load,
   input  logic [2:0] cmd_op,
   input  logic [3:0] cmd_dado,
   output logic [3:0] alu_a_out,
   output logic [3:0] alu_b_out,
   output logic [2:0] alu_op_out,
   input  logic [3:0] alu_resultado_in,
   output logic [3:0] acc_out,
   output logic       zero_flag,
   output logic       resp_valid,
   input  logic       resp_ready
`ifdef ULA_ACC_CONTADOR_EN
   ,
   output logic [7:0] op_count_out
`endif
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EXECUTA  = 2'd1,
      RESPONDE = 2'd2
   } state_t;

   state_t     state_reg;
   logic [3:0] acc_reg;
   logic [3:0] b_reg;
   logic [2:0] op_reg;
   logic       zero_reg;

   // Control FSM and datapath registers.
   // The operand and opcode registers only move on accept edges, and the
   // accumulator only on load-accept or result edges, so the ULA inputs are
   // steady throughout the EXECUTA cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= OCIOSO;
         acc_reg   <= 4'd0;
         zero_reg  <= 1'b1;
         b_reg     <= 4'd0;
         op_reg    <= 3'd0;
      end else begin
         case (state_reg)
            OCIOSO: begin
               // cmd_ready is 1 in this state whenever rst is low
               if (cmd_valid) begin
                  b_reg  <= cmd_dado;
                  op_reg <= cmd_op;
                  if (cmd_load) begin
                     // load bypasses the ULA and answers right away
                     acc_reg   <= cmd_dado;
                     zero_reg  <= (cmd_dado == 4'd0);
                     state_reg <= RESPONDE;
                  end else begin
                     state_reg <= EXECUTA;
                  end
               end
            end
            EXECUTA: begin
               // ULA has seen acc/b/op for the whole cycle; capture it
               acc_reg   <= alu_resultado_in;
               zero_reg  <= (alu_resultado_in == 4'd0);
               state_reg <= RESPONDE;
            end
            RESPONDE: begin
               if (resp_ready) begin
                  state_reg <= OCIOSO;
               end
            end
            default: begin
               state_reg <= OCIOSO;
            end
         endcase
      end
   end

   // Handshake flags are decoded from the state and held low during reset so
   // nothing upstream or downstream sees a transfer in the reset cycle.
   assign cmd_ready  = (state_reg == OCIOSO)   && !rst;
   assign resp_valid = (state_reg == RESPONDE) && !rst;

   assign alu_a_out  = acc_reg;
   assign alu_b_out  = b_reg;
   assign alu_op_out = op_reg;
   assign acc_out    = acc_reg;
   assign zero_flag  = zero_reg;

`ifdef ULA_ACC_CONTADOR_EN
   logic [7:0] count_reg;

   // Counts completed responses; natural 8-bit wrap from FFh to 00h.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= 8'd0;
      end else if (resp_valid && resp_ready) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   assign op_count_out = count_reg;
`endif

endmodule
